// File: rtl/accum_scheduler.sv
// Round-robin drain of the per-DTP result FIFOs into the accumulator, with
// result counting, accum_fin handshake and done/abort sequencing.
module accum_scheduler #(
    parameter int N_DTPS     = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 10,
    parameter int SRC_W      = (N_DTPS > 1) ? $clog2(N_DTPS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [CNT_W-1:0]             i_n_results,
    input  logic                         i_is_clf,
    input  logic                         i_abort,
    input  logic [N_DTPS-1:0]            i_fifo_empty,
    input  logic [N_DTPS*FIFO_WIDTH-1:0] i_fifo_front,
    output logic [N_DTPS-1:0]            o_fifo_pop,
    output logic [FIFO_WIDTH-1:0]        o_acc_data,
    output logic [SRC_W-1:0]             o_acc_src,
    output logic                         o_acc_vld,
    output logic                         o_is_clf,
    output logic                         o_accum_fin,
    output logic                         o_flush,
    input  logic                         i_clf_res_vld,
    input  logic                         i_rgs_res_vld,
    output logic                         o_busy,
    output logic                         o_done
);

    typedef enum logic [2:0] {IDLE, DRAIN, FINISH, WAIT_RES, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        target;
    logic [CNT_W-1:0]        count;
    logic [SRC_W-1:0]        rr_ptr;
    logic [SRC_W-1:0]        grant;
    logic [SRC_W-1:0]        cand;
    logic                    grant_vld;
    logic                    pop_en;
    logic [FIFO_WIDTH-1:0]   front [N_DTPS];

    for (genvar k = 0; k < N_DTPS; k++) begin : g_front
        assign front[k] = i_fifo_front[k*FIFO_WIDTH +: FIFO_WIDTH];
    end

    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int off);
        return SRC_W'((int'(base) + off) % N_DTPS);
    endfunction

    // Scan from farthest to nearest so the nearest non-empty FIFO after rr_ptr wins.
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        cand      = rr_ptr;
        for (int i = N_DTPS; i >= 1; i--) begin
            cand = rr_idx(rr_ptr, i);
            if (!i_fifo_empty[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    assign pop_en     = (state == DRAIN) && (count != target) && !i_abort && grant_vld;
    assign o_fifo_pop = pop_en ? (N_DTPS'(1) << grant) : '0;
    assign o_busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            target      <= '0;
            count       <= '0;
            rr_ptr      <= SRC_W'(N_DTPS - 1);
            o_acc_data  <= '0;
            o_acc_src   <= '0;
            o_acc_vld   <= 1'b0;
            o_is_clf    <= 1'b0;
            o_accum_fin <= 1'b0;
            o_flush     <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_acc_vld   <= pop_en;
            o_accum_fin <= 1'b0;
            o_flush     <= 1'b0;
            o_done      <= 1'b0;
            if (pop_en) begin
                o_acc_data <= front[grant];
                o_acc_src  <= grant;
                rr_ptr     <= grant;
                count      <= count + CNT_W'(1);
            end
            if (i_abort) begin
                state   <= IDLE;
                count   <= '0;
                o_flush <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (i_start) begin
                        state    <= DRAIN;
                        target   <= i_n_results;
                        o_is_clf <= i_is_clf;
                        count    <= '0;
                    end
                    // count reaches target the cycle the last word is on o_acc_data
                    DRAIN: if (count == target) begin
                        state       <= FINISH;
                        o_accum_fin <= 1'b1;
                    end
                    FINISH: state <= WAIT_RES;
                    WAIT_RES: if (o_is_clf ? i_clf_res_vld : i_rgs_res_vld) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accum_scheduler.sv
// Directed bench for accum_scheduler: table of drain scenarios plus
// hand-written abort and mid-inference reset sequences.
module tb_accum_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [CW-1:0]     i_n_results = '0;
    logic              i_is_clf = 1'b0;
    logic              i_abort = 1'b0;
    logic [N-1:0]      fifo_empty;
    logic [N*W-1:0]    fifo_front;
    logic [N-1:0]      o_fifo_pop;
    logic [W-1:0]      o_acc_data;
    logic [1:0]        o_acc_src;
    logic              o_acc_vld;
    logic              o_is_clf;
    logic              o_accum_fin;
    logic              o_flush;
    logic              i_clf_res_vld = 1'b0;
    logic              i_rgs_res_vld = 1'b0;
    logic              o_busy;
    logic              o_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    accum_scheduler #(.N_DTPS(N), .FIFO_WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_n_results(i_n_results),
        .i_is_clf(i_is_clf), .i_abort(i_abort), .i_fifo_empty(fifo_empty),
        .i_fifo_front(fifo_front), .o_fifo_pop(o_fifo_pop), .o_acc_data(o_acc_data),
        .o_acc_src(o_acc_src), .o_acc_vld(o_acc_vld), .o_is_clf(o_is_clf),
        .o_accum_fin(o_accum_fin), .o_flush(o_flush), .i_clf_res_vld(i_clf_res_vld),
        .i_rgs_res_vld(i_rgs_res_vld), .o_busy(o_busy), .o_done(o_done)
    );

    // FIFO model: FIFO k holds nw[k] words, word j = A000 | k<<8 | j
    int   nw [N];
    int   rd [N];
    logic clr_fifo = 1'b0;

    function automatic logic [15:0] word(input int k, input int j);
        return 16'hA000 | 16'((k & 15) << 8) | 16'(j & 255);
    endfunction

    always_comb begin
        fifo_empty = '0;
        fifo_front = '0;
        for (int k = 0; k < N; k++) begin
            fifo_empty[k]          = (rd[k] >= nw[k]);
            fifo_front[k*W +: W]   = word(k, rd[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (clr_fifo)         rd[k] <= 0;
            else if (o_fifo_pop[k]) rd[k] <= rd[k] + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [27:0] all_outs();
        return {o_fifo_pop, o_acc_data, o_acc_src, o_acc_vld, o_is_clf,
                o_accum_fin, o_flush, o_busy, o_done};
    endfunction

    task automatic load(input logic [3:0] mask, input int words);
        @(negedge clk);
        for (int k = 0; k < N; k++) nw[k] = mask[k] ? words : 0;
        clr_fifo = 1'b1;
        @(negedge clk);
        clr_fifo = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  mask;
        int          words;
        int          target;
        logic        clf;
        int          n_vld;
        logic [31:0] srcs;   // expected o_acc_src sequence, entry i at [2*i +: 2]
        int          fin_at; // cycles after start sample
    } scn_t;

    task automatic run_scn(input scn_t s);
        int nv, fin_at;
        int cnt [N];
        logic [1:0] es;
        load(s.mask, s.words);
        i_start = 1'b1; i_n_results = CW'(s.target); i_is_clf = s.clf;
        @(negedge clk);
        i_start = 1'b0;
        nv = 0; fin_at = -1; cnt = '{default: 0};
        for (int c = 1; c <= 60 && fin_at < 0; c++) begin
            if (o_acc_vld && nv < 16) begin
                es = s.srcs[2*nv +: 2];
                check({s.name, " src"}, 32'(o_acc_src), 32'(es));
                check({s.name, " data"}, 32'(o_acc_data), 32'(word(int'(es), cnt[es])));
                cnt[es]++;
                nv++;
            end
            if (o_accum_fin) fin_at = c;
            else @(negedge clk);
        end
        check({s.name, " vld count"}, nv, s.n_vld);
        check({s.name, " fin cycle"}, fin_at, s.fin_at);
        check({s.name, " mode/busy"}, {o_is_clf, o_busy}, {s.clf, 1'b1});
        @(negedge clk);
        if (s.clf) i_rgs_res_vld = 1'b1; else i_clf_res_vld = 1'b1;
        @(negedge clk);
        i_rgs_res_vld = 1'b0; i_clf_res_vld = 1'b0;
        check({s.name, " wrong-mode ignored"}, {o_done, o_busy}, 2'b01);
        if (s.clf) i_clf_res_vld = 1'b1; else i_rgs_res_vld = 1'b1;
        @(negedge clk);
        i_rgs_res_vld = 1'b0; i_clf_res_vld = 1'b0;
        check({s.name, " done pulse"}, {o_done, o_busy}, 2'b11);
        @(negedge clk);
        check({s.name, " back to idle"}, {o_done, o_busy, o_accum_fin}, 3'b000);
    endtask

    scn_t tbl [4];
    scn_t post_rst;

    initial begin
        int np;
        tbl[0] = '{name: "rr4x3",    mask: 4'hF, words: 3, target: 12, clf: 1'b0,
                   n_vld: 12, srcs: 32'h00E4E4E4, fin_at: 14};
        tbl[1] = '{name: "wrap13",   mask: 4'hA, words: 2, target: 4,  clf: 1'b1,
                   n_vld: 4,  srcs: 32'h000000DD, fin_at: 6};
        tbl[2] = '{name: "only2",    mask: 4'h4, words: 5, target: 5,  clf: 1'b0,
                   n_vld: 5,  srcs: 32'h000002AA, fin_at: 7};
        tbl[3] = '{name: "target0",  mask: 4'hF, words: 1, target: 0,  clf: 1'b1,
                   n_vld: 0,  srcs: 32'h0,        fin_at: 2};
        post_rst = '{name: "post-reset", mask: 4'hF, words: 1, target: 2, clf: 1'b0,
                     n_vld: 2, srcs: 32'h4, fin_at: 4};

        repeat (3) @(negedge clk);
        check("reset outputs", 32'(all_outs()), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", 32'(all_outs()), 32'h0);

        for (int t = 0; t < 4; t++) run_scn(tbl[t]);

        // Abort after 4 of 8 pops; a start during DRAIN must not retarget to 3.
        load(4'hF, 2);
        i_start = 1'b1; i_n_results = 10'd8; i_is_clf = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        np = 0;
        for (int c = 0; c < 20 && np < 4; c++) begin
            i_start = (c == 1);
            i_n_results = (c == 1) ? 10'd3 : 10'd8;
            #1;
            if (o_fifo_pop != '0) np++;
            check("abort no fin in drain", 32'(o_accum_fin), 32'h0);
            @(negedge clk);
        end
        i_start = 1'b0;
        check("abort pops before abort", np, 4);
        i_abort = 1'b1;
        #1;
        check("abort cycle no pop", 32'(o_fifo_pop), 32'h0);
        @(negedge clk);
        i_abort = 1'b0;
        check("abort flush/busy/fin/done", {o_flush, o_busy, o_accum_fin, o_done}, 4'b1000);
        check("abort total pops", rd[0] + rd[1] + rd[2] + rd[3], 4);
        @(negedge clk);
        check("flush one cycle", {o_flush, o_busy}, 2'b00);
        repeat (3) begin
            @(negedge clk);
            check("abort stays quiet", {o_accum_fin, o_done, o_busy, o_acc_vld}, 4'b0000);
        end

        // Async reset in the middle of a drain.
        load(4'hF, 3);
        i_start = 1'b1; i_n_results = 10'd12; i_is_clf = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-drain active", {o_busy, o_acc_vld}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'(all_outs()), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_scn(post_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
